jump_ctrl_pipe: RTL

Parametrised branch/jump control unit for the 5-stage MIPS pipeline. Jumps (j, jal, jr, jalr) redirect fetch at ID. Conditional branches (beq, bne) are predicted at ID by a table of 2-bit saturating counters and resolved at EX using the ALU Zero flag. A mispredict redirects fetch to the correct PC and flushes IF/ID. The unit also keeps saturating branch and mispredict statistics counters.

---
 rtl/jump_ctrl_pkg.sv | 43 ++++
 rtl/jump_ctrl_pipe_pht.sv | 52 +++++
 rtl/jump_ctrl_pipe.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/jump_ctrl_pkg.sv
// Shared decode constants, instruction class enum and predictor constants
// for the branch/jump control unit.
package jump_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    // Weakly not-taken: a branch must be seen taken once before it is predicted taken.
    localparam logic [1:0] PHT_RESET = 2'b01;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_BEQ  = 3'd1,
        CLS_BNE  = 3'd2,
        CLS_JREG = 3'd3,
        CLS_JIMM = 3'd4
    } br_class_e;

    // Classify an instruction from its opcode/funct fields.
    function automatic br_class_e decode_class(input logic [5:0] opcode,
                                               input logic [5:0] funct);
        br_class_e cls;
        cls = CLS_NONE;
        case (opcode)
            OP_BEQ:       cls = CLS_BEQ;
            OP_BNE:       cls = CLS_BNE;
            OP_J, OP_JAL: cls = CLS_JIMM;
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    cls = CLS_JREG;
                end
            end
            default:      cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/jump_ctrl_pipe_pht.sv
// Pattern history table: DEPTH two-bit saturating counters, one combinational
// read port returning the prediction bit, one clocked update port.
module pht_2bit
    import jump_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [DEPTH-1:0][1:0] ctr_q;
    logic [DEPTH-1:0][1:0] ctr_d;

    // Read returns the current (pre-update) counter, so a same-cycle
    // update is not visible to the reader.
    assign rd_taken = ctr_q[rd_idx][1];

    // Saturating update of the addressed counter, all others hold.
    always_comb begin
        ctr_d = ctr_q;
        if (upd_en) begin
            if (upd_taken) begin
                if (ctr_q[upd_idx] != 2'b11) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] + 2'b01;
                end
            end else begin
                if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'b01;
                end
            end
        end
    end

    // Counter storage with asynchronous return to weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= PHT_RESET;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/jump_ctrl_pipe.sv
// Branch/jump control for the 5-stage pipeline: jumps and predicted-taken
// branches redirect at ID, conditional branches resolve at EX, mispredicts
// redirect and flush IF/ID and ID/EX. Keeps saturating branch statistics.
module jump_ctrl_pipe
    import jump_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int PHT_DEPTH = 16,
    parameter int CNT_W     = 16,
    parameter int PREDICT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [15:0]       id_imm,
    input  logic [25:0]       id_jaddr,
    input  logic [ADDR_W-1:0] id_rs_data,
    input  logic              stall,
    input  logic              ex_zero,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_if,
    output logic              flush_id,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    typedef struct packed {
        logic              valid;
        br_class_e         cls;
        logic              pred;
        logic [ADDR_W-1:0] br_tgt;
        logic [ADDR_W-1:0] seq;
        logic [IDX_W-1:0]  idx;
    } ex_reg_t;

    br_class_e         id_cls;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] imm_off;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic [IDX_W-1:0]  pht_idx;
    logic              pht_taken;
    logic              id_is_br;
    logic              id_pred;

    ex_reg_t           ex_q;
    ex_reg_t           ex_d;
    logic              ex_resolve;
    logic              ex_taken;
    logic              ex_mispred;

    logic [CNT_W-1:0]  branch_cnt_q;
    logic [CNT_W-1:0]  branch_cnt_d;
    logic [CNT_W-1:0]  mispred_cnt_q;
    logic [CNT_W-1:0]  mispred_cnt_d;

    assign id_cls  = id_valid ? decode_class(id_opcode, id_funct) : CLS_NONE;
    assign seq     = id_pc + ADDR_W'(4);
    assign imm_off = {{(ADDR_W-18){id_imm[15]}}, id_imm, 2'b00};
    assign br_tgt  = seq + imm_off;
    assign pht_idx = id_pc[IDX_W+1:2];

    // Jump target keeps the PC region bits above the 28-bit jump window.
    generate
        if (ADDR_W > 28) begin : g_jtgt_region
            assign j_tgt = {seq[ADDR_W-1:28], id_jaddr, 2'b00};
        end else begin : g_jtgt_flat
            assign j_tgt = {id_jaddr, 2'b00};
        end
    endgenerate

    assign id_is_br = (id_cls == CLS_BEQ) || (id_cls == CLS_BNE);
    assign id_pred  = (PREDICT != 0) && id_is_br && pht_taken;

    assign ex_resolve = ex_q.valid && ((ex_q.cls == CLS_BEQ) || (ex_q.cls == CLS_BNE));
    assign ex_taken   = (ex_q.cls == CLS_BEQ) ? ex_zero : ~ex_zero;
    assign ex_mispred = ex_resolve && (ex_taken != ex_q.pred);

    pht_2bit #(
        .DEPTH (PHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_pht (
        .clk       (clk),
        .rst_n     (rst),
        .rd_idx    (pht_idx),
        .rd_taken  (pht_taken),
        .upd_en    ((PREDICT != 0) && ex_resolve),
        .upd_idx   (ex_q.idx),
        .upd_taken (ex_taken)
    );

    // Redirect/flush selection: EX mispredict wins over any ID redirect;
    // everything is held low while reset is asserted.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        if (rst) begin
            if (ex_mispred) begin
                redirect    = 1'b1;
                redirect_pc = ex_taken ? ex_q.br_tgt : ex_q.seq;
                flush_if    = 1'b1;
                flush_id    = 1'b1;
            end else if (!stall) begin
                if (id_cls == CLS_JIMM) begin
                    redirect    = 1'b1;
                    redirect_pc = j_tgt;
                    flush_if    = 1'b1;
                end else if (id_cls == CLS_JREG) begin
                    redirect    = 1'b1;
                    redirect_pc = id_rs_data;
                    flush_if    = 1'b1;
                end else if (id_pred) begin
                    redirect    = 1'b1;
                    redirect_pc = br_tgt;
                    flush_if    = 1'b1;
                end
            end
        end
    end

    // Next EX contents: a bubble on stall or when the ID instruction is squashed.
    always_comb begin
        ex_d        = '0;
        ex_d.cls    = CLS_NONE;
        if (!stall && !ex_mispred) begin
            ex_d.valid  = id_valid;
            ex_d.cls    = id_cls;
            ex_d.pred   = id_pred;
            ex_d.br_tgt = br_tgt;
            ex_d.seq    = seq;
            ex_d.idx    = pht_idx;
        end
    end

    // Saturating statistics.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (ex_resolve && !(&branch_cnt_q)) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (ex_mispred && !(&mispred_cnt_q)) begin
            mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    // Pipeline register and statistics, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q          <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            ex_q          <= ex_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
